// File: rtl/nonogram_pkg.sv
// Shared sizing and state encoding for the nonogram solve path.
// Contents:
//   MAX_ROWS, MAX_COLS, LARGEST_DIM, MAX_NUM_OPTIONS, NUM_LINES : board limits
//   ROW_W, COL_W, LINE_W, OPT_W                                 : field widths
//   sched_state_t                                               : scheduler FSM states
package nonogram_pkg;

   localparam int MAX_ROWS        = 11;
   localparam int MAX_COLS        = 11;
   localparam int LARGEST_DIM     = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
   localparam int MAX_NUM_OPTIONS = 84;
   localparam int NUM_LINES       = MAX_ROWS + MAX_COLS;

   localparam int ROW_W  = $clog2(MAX_ROWS);
   localparam int COL_W  = $clog2(MAX_COLS);
   localparam int LINE_W = $clog2(NUM_LINES);
   localparam int OPT_W  = $clog2(MAX_NUM_OPTIONS);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      NEXT,
      FINISH
   } sched_state_t;

endpackage

// File: rtl/line_count_table.sv
// Per-line surviving option counts for one board.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears every entry)
//   load, load_data : parallel load of all entries (start of a solve)
//   wr_en/addr/data : single-entry update after a line is solved
//   rd_addr/rd_data : single combinational read port
//   scan_clr/scan_en: reset / advance the zero-scan pointer
//   scan_ptr        : current scan position
//   scan_zero       : entry under the scan pointer holds zero
module line_count_table
   import nonogram_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic [NUM_LINES-1:0][OPT_W-1:0]  load_data,
   input  logic                             wr_en,
   input  logic [LINE_W-1:0]                wr_addr,
   input  logic [OPT_W-1:0]                 wr_data,
   input  logic [LINE_W-1:0]                rd_addr,
   output logic [OPT_W-1:0]                 rd_data,
   input  logic                             scan_clr,
   input  logic                             scan_en,
   output logic [LINE_W-1:0]                scan_ptr,
   output logic                             scan_zero
);

   logic [OPT_W-1:0] counts [NUM_LINES];

   // Addresses beyond the last line read as zero instead of indexing out of range.
   assign rd_data   = (rd_addr < LINE_W'(NUM_LINES)) ? counts[rd_addr] : '0;
   assign scan_zero = (scan_ptr < LINE_W'(NUM_LINES)) ? (counts[scan_ptr] == '0) : 1'b1;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the values present before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the table is small and a cleared table is observable on
         // line_count after reset, so it is reset like ordinary registers.
         for (int i = 0; i < NUM_LINES; i++) counts[i] <= '0;
         scan_ptr <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < NUM_LINES; i++) counts[i] <= load_data[i];
         end else if (wr_en && (wr_addr < LINE_W'(NUM_LINES))) begin
            counts[wr_addr] <= wr_data;
         end

         if (scan_clr)     scan_ptr <= '0;
         else if (scan_en) scan_ptr <= scan_ptr + LINE_W'(1);
      end
   end

endmodule

// File: rtl/solve_pass_scheduler.sv
// Sequences solver passes over every row then every column of a parsed board.
// Ports:
//   clk, rst                   : 50 MHz clock, synchronous active-high reset
//   start                      : board parsed; latches dimensions and counts
//   num_rows, num_cols         : board dimensions m, n
//   options_per_line           : initial counts, rows at 0..m-1, columns at m..m+n-1
//   line_valid/line_ready      : descriptor handshake towards the solver
//   line_index, line_is_row    : packed line index and its orientation
//   line_count                 : options the solver pops for this line
//   line_done, line_changed,
//   line_new_count             : solver completion and its results
//   board_solved               : solver reports every cell known
//   busy, done, unsolvable     : solve status; done pulses once at the end
//   pass_count                 : completed passes
module solve_pass_scheduler
   import nonogram_pkg::*;
#(
   parameter  int MAX_PASSES = 64,
   localparam int PASS_W     = $clog2(MAX_PASSES + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ROW_W-1:0]                 num_rows,
   input  logic [COL_W-1:0]                 num_cols,
   input  logic [NUM_LINES-1:0][OPT_W-1:0]  options_per_line,
   output logic                             line_valid,
   input  logic                             line_ready,
   output logic [LINE_W-1:0]                line_index,
   output logic                             line_is_row,
   output logic [OPT_W-1:0]                 line_count,
   input  logic                             line_done,
   input  logic                             line_changed,
   input  logic [OPT_W-1:0]                 line_new_count,
   input  logic                             board_solved,
   output logic                             busy,
   output logic                             done,
   output logic                             unsolvable,
   output logic [PASS_W-1:0]                pass_count
);

   sched_state_t      state_q, state_d;
   logic [ROW_W-1:0]  rows_q, rows_d;
   logic [COL_W-1:0]  cols_q, cols_d;
   logic [LINE_W-1:0] idx_q, idx_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic              changed_q, changed_d;   // any line changed in this pass
   logic              zero_q, zero_d;         // last solved line came back empty
   logic              unsolv_q, unsolv_d;

   logic              tbl_load, tbl_wr, scan_clr, scan_en, scan_zero;
   logic [LINE_W-1:0] scan_ptr;
   logic [LINE_W-1:0] line_last;

   line_count_table u_table (
      .clk       (clk),
      .rst       (rst),
      .load      (tbl_load),
      .load_data (options_per_line),
      .wr_en     (tbl_wr),
      .wr_addr   (idx_q),
      .wr_data   (line_new_count),
      .rd_addr   (idx_q),
      .rd_data   (line_count),
      .scan_clr  (scan_clr),
      .scan_en   (scan_en),
      .scan_ptr  (scan_ptr),
      .scan_zero (scan_zero)
   );

   assign line_last   = LINE_W'(rows_q) + LINE_W'(cols_q) - LINE_W'(1);
   assign line_index  = idx_q;
   assign line_is_row = (idx_q < LINE_W'(rows_q));
   assign unsolvable  = unsolv_q;
   assign pass_count  = pass_q;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      changed_d  = changed_q;
      zero_d     = zero_q;
      unsolv_d   = unsolv_q;
      tbl_load   = 1'b0;
      tbl_wr     = 1'b0;
      scan_clr   = 1'b0;
      scan_en    = 1'b0;
      line_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               tbl_load  = 1'b1;
               scan_clr  = 1'b1;
               rows_d    = num_rows;
               cols_d    = num_cols;
               idx_d     = '0;
               pass_d    = '0;
               changed_d = 1'b0;
               zero_d    = 1'b0;
               unsolv_d  = 1'b0;
               state_d   = CHECK;
            end
         end

         // One table entry per cycle; any empty line makes the board unsolvable.
         CHECK: begin
            busy = 1'b1;
            if (rows_q == '0 || cols_q == '0 || scan_zero) begin
               unsolv_d = 1'b1;
               state_d  = FINISH;
            end else if (scan_ptr == line_last) begin
               state_d = ISSUE;
            end else begin
               scan_en = 1'b1;
            end
         end

         ISSUE: begin
            busy       = 1'b1;
            line_valid = 1'b1;
            if (line_ready) state_d = WAIT;
         end

         // An empty result is only recorded here; NEXT decides the outcome so
         // board_solved keeps priority over it.
         WAIT: begin
            busy = 1'b1;
            if (line_done) begin
               tbl_wr    = 1'b1;
               changed_d = changed_q | line_changed;
               zero_d    = (line_new_count == '0);
               state_d   = NEXT;
            end
         end

         NEXT: begin
            busy = 1'b1;
            if (board_solved) begin
               unsolv_d = 1'b0;
               state_d  = FINISH;
            end else if (zero_q) begin
               unsolv_d = 1'b1;
               state_d  = FINISH;
            end else if (idx_q != line_last) begin
               idx_d   = idx_q + LINE_W'(1);
               state_d = ISSUE;
            end else begin
               pass_d = pass_q + PASS_W'(1);
               if (!changed_q || pass_d == PASS_W'(MAX_PASSES)) begin
                  unsolv_d = 1'b1;
                  state_d  = FINISH;
               end else begin
                  changed_d = 1'b0;
                  idx_d     = '0;
                  state_d   = ISSUE;
               end
            end
         end

         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rows_q    <= '0;
         cols_q    <= '0;
         idx_q     <= '0;
         pass_q    <= '0;
         changed_q <= 1'b0;
         zero_q    <= 1'b0;
         unsolv_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         changed_q <= changed_d;
         zero_q    <= zero_d;
         unsolv_q  <= unsolv_d;
      end
   end

endmodule
